mvm_host_driver: RTL and testbench

MVM_HOST_DRIVER -- requirements
Module: mvm_host_driver

---
 rtl/mvm_host_driver.sv | 174 +++++++++++++++++
 tb/tb_mvm_host_driver.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvm_host_driver.sv
// Host-side sequencer for an MVM core: buffers A and x from an upstream stream, replays
// them to the core with load/start strobes, then captures K results and drains them.
module mvm_host_driver #(
  parameter int unsigned K       = 8,
  parameter int unsigned B       = 8,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [B-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             m_reset,
  output logic             m_loadMatrix,
  output logic             m_loadVector,
  output logic             m_start,
  output logic [B-1:0]     m_data_in,
  input  logic             m_done,
  input  logic [2*B-1:0]   m_data_out,
  output logic [2*B-1:0]   out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             err
);

  localparam int unsigned NA = K * K;
  localparam int unsigned NT = K * K + K;
  localparam int unsigned CW = (NT > 1) ? $clog2(NT) : 1;
  localparam int unsigned RW = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [3:0] {
    StFill, StMrst, StLdm, StSendm, StGap1, StLdv,
    StSendv, StGap2, StStart, StWait, StCapt, StDrain
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   wcnt_q, wcnt_d;
  // Low for the first cycle after reset so in_ready stays 0 there.
  logic            live_q;
  logic [B-1:0]    elem_q [NT];
  logic [2*B-1:0]  res_q [K];
  logic            accept;
  logic            clear;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wcnt_d       = wcnt_q;
    accept       = 1'b0;
    clear        = 1'b0;
    in_ready     = 1'b0;
    m_reset      = 1'b0;
    m_loadMatrix = 1'b0;
    m_loadVector = 1'b0;
    m_start      = 1'b0;
    m_data_in    = '0;
    out_valid    = 1'b0;
    out_data     = '0;
    out_last     = 1'b0;
    err          = 1'b0;

    unique case (state_q)
      StFill: begin
        in_ready = live_q;
        accept   = in_valid && live_q;
        if (accept) begin
          if (cnt_q == CW'(NT - 1)) begin
            cnt_d   = '0;
            state_d = StMrst;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StMrst: begin
        m_reset = 1'b1;
        state_d = StLdm;
      end
      StLdm: begin
        m_loadMatrix = 1'b1;
        state_d      = StSendm;
      end
      StSendm: begin
        // cnt keeps running past K*K so SENDV continues at x[0].
        m_data_in = elem_q[cnt_q];
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CW'(NA - 1)) state_d = StGap1;
      end
      StGap1: state_d = StLdv;
      StLdv: begin
        m_loadVector = 1'b1;
        state_d      = StSendv;
      end
      StSendv: begin
        m_data_in = elem_q[cnt_q];
        if (cnt_q == CW'(NT - 1)) begin
          cnt_d   = '0;
          state_d = StGap2;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGap2: state_d = StStart;
      StStart: begin
        m_start = 1'b1;
        wcnt_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        if (m_done) begin
          cnt_d   = '0;
          state_d = StCapt;
        end else if (wcnt_q == TW'(TIMEOUT - 1)) begin
          err     = 1'b1;
          clear   = 1'b1;
          cnt_d   = '0;
          wcnt_d  = '0;
          state_d = StFill;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      StCapt: begin
        if (cnt_q == CW'(K - 1)) begin
          cnt_d   = '0;
          state_d = StDrain;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDrain: begin
        out_valid = 1'b1;
        out_data  = res_q[cnt_q[RW-1:0]];
        out_last  = (cnt_q == CW'(K - 1));
        if (out_ready) begin
          if (out_last) begin
            cnt_d   = '0;
            state_d = StFill;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StFill;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      live_q  <= 1'b0;
      for (int unsigned i = 0; i < NT; i++) elem_q[i] <= '0;
      for (int unsigned i = 0; i < K; i++) res_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      live_q  <= 1'b1;
      if (clear) begin
        for (int unsigned i = 0; i < NT; i++) elem_q[i] <= '0;
        for (int unsigned i = 0; i < K; i++) res_q[i] <= '0;
      end else begin
        if (accept) elem_q[cnt_q] <= in_data;
        if (state_q == StCapt) res_q[cnt_q[RW-1:0]] <= m_data_out;
      end
    end
  end

endmodule

// File: tb/tb_mvm_host_driver.sv
// Directed bench for mvm_host_driver with a behavioural MVM core model that answers the
// driver's load/start protocol and streams back products computed from what it received.
module tb_mvm_host_driver;

  localparam int K = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        m_reset, m_loadMatrix, m_loadVector, m_start;
  logic [7:0]  m_data_in;
  logic        m_done = 1'b0;
  logic [15:0] m_data_out = '0;
  logic [15:0] out_data;
  logic        out_valid, out_last;
  logic        out_ready = 1'b0;
  logic        err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc = 0;

  logic [7:0]  job  [72];
  logic [15:0] yexp [8];

  // core model state
  logic signed [7:0] ma [64];
  logic signed [7:0] vx [8];
  logic [15:0]       yv [8];
  logic [6:0]        ai = '0;
  logic [3:0]        vi = '0;
  logic [3:0]        oi = 4'd8;
  int                cd = 0;
  bit                rx_a = 1'b0, rx_v = 1'b0, core_en = 1'b1;
  int                t_ldm = 0, t_ldv = 0, t_start = 0, acc_at_ldm = 0;

  mvm_host_driver #(.K(8), .B(8), .TIMEOUT(1024)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .m_reset      (m_reset),
    .m_loadMatrix (m_loadMatrix),
    .m_loadVector (m_loadVector),
    .m_start      (m_start),
    .m_data_in    (m_data_in),
    .m_done       (m_done),
    .m_data_out   (m_data_out),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .err          (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready) acc <= acc + 1;
  end

  // MVM core: m_done 5 cycles after m_start, y[0..7] in the following 8 cycles.
  initial begin
    int s;
    forever begin
      @(posedge clk); #1;
      if (oi < 4'd8) begin
        m_data_out = yv[oi[2:0]];
        oi = oi + 4'd1;
      end else begin
        m_data_out = 16'hBEEF;
      end
      m_done = 1'b0;
      if (cd > 0) begin
        cd = cd - 1;
        if (cd == 0 && core_en) begin
          m_done = 1'b1;
          oi = 4'd0;
        end
      end
      if (m_start) begin
        for (int i = 0; i < K; i++) begin
          s = 0;
          for (int j = 0; j < K; j++) s = s + ma[6'(i * K + j)] * vx[3'(j)];
          yv[3'(i)] = s[15:0];
        end
        cd = 5;
        t_start = cyc;
      end
      if (rx_a) begin
        ma[ai[5:0]] = m_data_in;
        ai = ai + 7'd1;
        if (ai == 7'd64) rx_a = 1'b0;
      end
      if (rx_v) begin
        vx[vi[2:0]] = m_data_in;
        vi = vi + 4'd1;
        if (vi == 4'd8) rx_v = 1'b0;
      end
      if (m_loadMatrix) begin
        rx_a = 1'b1;
        ai = '0;
        t_ldm = cyc;
        acc_at_ldm = acc;
      end
      if (m_loadVector) begin
        rx_v = 1'b1;
        vi = '0;
        t_ldv = cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic feed(input bit stall);
    int i = 0;
    int g = 0;
    bit tg = 1'b0;
    bit hs;
    while (i < 72 && g < 2000) begin
      in_data  = job[7'(i)];
      in_valid = stall ? tg : 1'b1;
      hs = in_valid && in_ready;
      step();
      if (hs) i++;
      tg = ~tg;
      g++;
    end
    in_valid = 1'b0;
    chk("feed_count", i, 72);
  endtask

  task automatic drain(input int bpi, input int bpl);
    int g;
    for (int k = 0; k < K; k++) begin
      g = 0;
      while (!out_valid && g < 3000) begin
        step();
        g++;
      end
      chk("out_valid", out_valid, 1);
      if (k == bpi) begin
        out_ready = 1'b0;
        for (int s = 0; s < bpl; s++) begin
          step();
          chk("hold_data", out_data, yexp[3'(k)]);
        end
        chk("hold_valid", out_valid, 1);
        chk("hold_last", out_last, 0);
      end
      chk("out_data", out_data, yexp[3'(k)]);
      chk("out_last", out_last, (k == K - 1));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    chk("back_to_fill", in_ready, 1);
    chk("valid_drop", out_valid, 0);
  endtask

  task automatic set_identity(input bit rev);
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) job[7'(i * K + j)] = (i == j) ? 8'd1 : 8'd0;
      job[7'(64 + i)] = rev ? 8'(8 - i) : 8'(i + 1);
      yexp[3'(i)]     = rev ? 16'(8 - i) : 16'(i + 1);
    end
  endtask

  initial begin
    int g;
    int base;
    int v;

    // reset behaviour
    reset = 1'b0;
    repeat (3) step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_strobes", {m_reset, m_loadMatrix, m_loadVector, m_start}, 0);
    chk("rst_m_data_in", m_data_in, 0);
    chk("rst_out", {out_valid, out_last, err}, 0);
    chk("rst_out_data", out_data, 0);
    reset = 1'b1;
    step();
    chk("ready_after_rst", in_ready, 1);

    // identity, x = 1..8
    set_identity(1'b0);
    feed(1'b0);
    drain(-1, 0);

    // sign: A = -1, x = 127 -> -1016
    for (int i = 0; i < 72; i++) job[7'(i)] = (i < 64) ? 8'hFF : 8'h7F;
    for (int i = 0; i < K; i++) yexp[3'(i)] = 16'hFC08;
    feed(1'b0);
    drain(-1, 0);

    // upstream stall: A[i][j] = i+j, x = 1..8 -> y[i] = 36i + 168
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) job[7'(i * K + j)] = 8'(i + j);
      job[7'(64 + i)] = 8'(i + 1);
      yexp[3'(i)] = 16'(36 * i + 168);
    end
    base = acc;
    feed(1'b1);
    drain(-1, 0);
    chk("accepts_before_ldm", acc_at_ldm - base, 72);
    chk("ldm_to_ldv", t_ldv - t_ldm, 66);
    chk("ldv_to_start", t_start - t_ldv, 10);

    // backpressure at y[3]: A[i][j] = i-j (not symmetric), x = 1..8 -> y[i] = 36i - 168
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) job[7'(i * K + j)] = 8'(i - j);
      job[7'(64 + i)] = 8'(i + 1);
      v = 36 * i - 168;
      yexp[3'(i)] = v[15:0];
    end
    feed(1'b0);
    drain(3, 20);

    // timeout
    core_en = 1'b0;
    set_identity(1'b0);
    feed(1'b0);
    g = 0;
    while (!err && g < 3000) begin
      step();
      g++;
    end
    chk("err_seen", err, 1);
    chk("err_delay", cyc - t_start, 1024);
    step();
    chk("err_pulse", err, 0);
    chk("ready_after_to", in_ready, 1);
    core_en = 1'b1;

    // reset at the 10th SENDM cycle, then a clean job
    feed(1'b0);
    g = 0;
    while (!m_loadMatrix && g < 100) begin
      step();
      g++;
    end
    chk("ldm_seen", m_loadMatrix, 1);
    repeat (10) step();
    chk("sendm_elem9", m_data_in, 1);
    reset = 1'b0;
    step();
    chk("abort_strobes", {m_reset, m_loadMatrix, m_loadVector, m_start, in_ready}, 0);
    chk("abort_out", {out_valid, out_last, err}, 0);
    chk("abort_data", {m_data_in, out_data}, 0);
    reset = 1'b1;
    step();
    chk("ready_after_abort", in_ready, 1);
    set_identity(1'b1);
    feed(1'b0);
    drain(-1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
